oam_dma_arbiter: RTL and testbench
==================================

Name: oam_dma_arbiter

Overview:
- Owns the CPU system bus and arbitrates it between the 6502 core and the sprite DMA engine.
- In IDLE it passes the CPU bus straight through.
- A CPU write to the DMA trigger register ($4014) latches a source page and then halts the CPU by gating its chip-enable.
- It then copies 256 bytes from {page,00..FF} to the PPU OAM data port ($2004), and finally returns the bus to the CPU.

Parameters:
- DMA_REG, 16'h4014, trigger register address.
- OAM_REG, 16'h2004, destination write address.

Ports:
- clock  in  1  system clock, 25 MHz.
- reset_n  in  1  synchronous, active-low reset.
- ce_in  in  1  global CPU tick enable. DMA advances only on ticks.
- cpu_a  in  16  CPU address.
- cpu_d  in  8  CPU write data.
- cpu_r  in  1  CPU read strobe.
- cpu_w  in  1  CPU write strobe.
- cpu_ce  out  1  chip-enable to the CPU core.
- bus_a  out  16  address to the memory map.
- bus_d  out  8  write data to the memory map.
- bus_r  out  1  read strobe to the memory map.
- bus_w  out  1  write strobe to the memory map.
- bus_i  in  8  read data from the memory map.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset is synchronous, active-low, on clock. On reset:
  - state=IDLE, page=0, idx=0, latch=0, parity=0.
  - Outputs follow IDLE pass-through, so cpu_ce=ce_in and busy=0.
- Tick definition: a clock edge with ce_in=1. All state, idx and parity changes occur only on ticks; everything holds otherwise.
- parity toggles on every tick from reset, regardless of state.
- Output muxing is combinational from state:
  - IDLE: bus_a=cpu_a, bus_d=cpu_d, bus_r=cpu_r, bus_w=cpu_w, cpu_ce=ce_in.
  - Any other state: cpu_ce=0.
  - READ: bus_a={page,idx}, bus_r=1, bus_w=0.
  - WRITE: bus_a=OAM_REG, bus_d=latch, bus_w=1, bus_r=0.
  - HALT and ALIGN: bus_r=0, bus_w=0, bus_a=OAM_REG, bus_d=latch.
- FSM:
  - IDLE: on a tick with cpu_w=1 and cpu_a=DMA_REG: page<=cpu_d, idx<=0, go to HALT. The trigger write itself is also passed through to the bus. A write with ce_in=0 is ignored.
  - HALT: one tick. If parity=1 at that tick, go to ALIGN; else go to READ.
  - ALIGN: one tick, then go to READ.
  - READ: on the tick, latch<=bus_i and go to WRITE.
  - WRITE: on the tick, if idx=8'hFF go to IDLE; else idx<=idx+1 and go to READ.
- Timing:
  - Halted ticks are exactly 513 (even start) or 514 (odd start).
  - cpu_ce returns to ce_in in the cycle after the final WRITE tick.
  - idx is 8 bits. The source address never carries into the page byte; page FF reads FF00..FFFF.
- Memory timing contract: bus_i is sampled on the tick that leaves READ. The memory map must return data within one clock of bus_a changing. ce_in is never high on two consecutive clocks.
- CPU core state is frozen by cpu_ce=0; no CPU strobes are forwarded while busy.
- A new trigger cannot occur while busy, since the CPU is halted. Any cpu_w seen while busy is ignored.
- Reset mid-transfer aborts immediately to IDLE. No further bus_w is issued, and cpu_ce=ce_in from the next cycle.

Test Plan:
- Pass-through: in IDLE, cpu_a=16'h0123, cpu_r=1 -> bus_a=16'h0123, bus_r=1, cpu_ce tracks ce_in, busy=0.
- Even-start DMA: ce_in every 2nd clock, RAM 0x0200..0x02FF holds idx^8'h5A, write 8'h02 to $4014 with parity=1 at the trigger tick (so parity=0 at the HALT tick) -> bus_w at $2004 pulses exactly 256 times with data 5A,5B,...; exactly 513 ticks have cpu_ce=0.
- Odd-start DMA: same as above but with parity=0 at the trigger tick (parity=1 at the HALT tick) -> ALIGN state visited once; exactly 514 halted ticks; data sequence identical.
- Page FF wrap: trigger with 8'hFF -> last read address 16'hFFFF; next bus_a after the final WRITE equals cpu_a; no access to 16'h0000.
- Sparse ce: ce_in=1 once per 12 clocks -> state, idx and parity unchanged on non-tick edges; per-byte ordering READ then WRITE preserved.
- Reset mid-transfer: assert reset_n=0 at idx=8'h40 in READ -> next cycle busy=0, cpu_ce=ce_in, no further $2004 writes; a fresh trigger afterwards starts from idx=0.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter
//
// Owns the CPU system bus and shares it between the 6502 core and the sprite
// DMA engine. While idle the CPU bus is passed straight through to the memory
// map. A CPU write to the DMA trigger register latches a source page and then
// halts the CPU by gating its chip-enable. The engine copies 256 bytes from
// {page,00..FF} to the PPU OAM data port and then hands the bus back.
//
// Ports:
//   clock    - system clock
//   reset_n  - synchronous, active-low reset
//   ce_in    - global CPU tick enable; the engine only advances on ticks
//   cpu_a    - CPU address
//   cpu_d    - CPU write data
//   cpu_r    - CPU read strobe
//   cpu_w    - CPU write strobe
//   cpu_ce   - chip-enable to the CPU core (held low while the DMA owns the bus)
//   bus_a    - address to the memory map
//   bus_d    - write data to the memory map
//   bus_r    - read strobe to the memory map
//   bus_w    - write strobe to the memory map
//   bus_i    - read data from the memory map
//   busy     - high whenever the engine is not idle
// ---------------------------------------------------------------------------
module oam_dma_arbiter #(
   parameter logic [15:0] DMA_REG = 16'h4014,
   parameter logic [15:0] OAM_REG = 16'h2004
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ce_in,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d,
   input  logic        cpu_r,
   input  logic        cpu_w,
   output logic        cpu_ce,
   output logic [15:0] bus_a,
   output logic [7:0]  bus_d,
   output logic        bus_r,
   output logic        bus_w,
   input  logic [7:0]  bus_i,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   state_t      state_q,  state_d;
   logic [7:0]  page_q,   page_d;
   logic [7:0]  idx_q,    idx_d;
   logic [7:0]  latch_q,  latch_d;
   logic        parity_q, parity_d;

   // Next-state values are computed as if the coming edge were a tick; the
   // register process only commits them when ce_in is high, so every piece
   // of state simply holds on non-tick edges.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         page_q   <= 8'h00;
         idx_q    <= 8'h00;
         latch_q  <= 8'h00;
         parity_q <= 1'b0;
      end else if (ce_in) begin
         state_q  <= state_d;
         page_q   <= page_d;
         idx_q    <= idx_d;
         latch_q  <= latch_d;
         parity_q <= parity_d;
      end
   end

   // Next-state logic and output muxing.
   // parity is a free-running tick phase: it decides whether the halt needs
   // one extra alignment tick so that reads always land on the same phase.
   // Outside IDLE the CPU is frozen, so none of its strobes reach the bus and
   // the default bus view is an inactive access parked on the OAM port.
   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      idx_d    = idx_q;
      latch_d  = latch_q;
      parity_d = ~parity_q;

      cpu_ce   = 1'b0;
      busy     = 1'b1;
      bus_a    = OAM_REG;
      bus_d    = latch_q;
      bus_r    = 1'b0;
      bus_w    = 1'b0;

      case (state_q)
         IDLE: begin
            cpu_ce = ce_in;
            busy   = 1'b0;
            bus_a  = cpu_a;
            bus_d  = cpu_d;
            bus_r  = cpu_r;
            bus_w  = cpu_w;
            // The trigger write itself still reaches the bus above.
            if (cpu_w && (cpu_a == DMA_REG)) begin
               page_d  = cpu_d;
               idx_d   = 8'h00;
               state_d = HALT;
            end
         end

         HALT: begin
            state_d = parity_q ? ALIGN : READ;
         end

         ALIGN: begin
            state_d = READ;
         end

         READ: begin
            // idx is only 8 bits, so the source never carries into the page.
            bus_a   = {page_q, idx_q};
            bus_r   = 1'b1;
            latch_d = bus_i;
            state_d = WRITE;
         end

         WRITE: begin
            bus_w = 1'b1;
            if (idx_q == 8'hFF) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = READ;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_arbiter
//
// Directed bench for the OAM DMA arbiter. A 64 KiB array stands in for the
// memory map and answers reads combinationally. Inputs change just after the
// falling edge and outputs are sampled 1 ns later, well clear of the rising
// edge. The bench tracks the tick phase itself from reset so it can choose
// even- or odd-start transfers and predict the number of halted ticks.
// ---------------------------------------------------------------------------
module tb_oam_dma_arbiter;

   localparam logic [15:0] DMA_REG = 16'h4014;
   localparam logic [15:0] OAM_REG = 16'h2004;

   logic        clock;
   logic        reset_n;
   logic        ce_in;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_d;
   logic        cpu_r;
   logic        cpu_w;
   logic        cpu_ce;
   logic [15:0] bus_a;
   logic [7:0]  bus_d;
   logic        bus_r;
   logic        bus_w;
   logic [7:0]  bus_i;
   logic        busy;

   logic [7:0]  mem [0:65535];

   int checks    = 0;
   int errors    = 0;
   int tickCount = 0;

   int writes, reads, halted, quiet;
   int addrErr, dataErr, orderErr, stableErr, cpuCeErr, strayW;
   logic        done;
   logic        aborted;
   logic [15:0] lastRead;

   assign bus_i = mem[bus_a];

   oam_dma_arbiter #(
      .DMA_REG(DMA_REG),
      .OAM_REG(OAM_REG)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .ce_in   (ce_in),
      .cpu_a   (cpu_a),
      .cpu_d   (cpu_d),
      .cpu_r   (cpu_r),
      .cpu_w   (cpu_w),
      .cpu_ce  (cpu_ce),
      .bus_a   (bus_a),
      .bus_d   (bus_d),
      .bus_r   (bus_r),
      .bus_w   (bus_w),
      .bus_i   (bus_i),
      .busy    (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive ce_in for the coming rising edge and let the outputs settle.
   task automatic applyStimulus(input logic ce);
      ce_in = ce;
      #1;
   endtask

   // Account for the coming rising edge, then move to the next sample point.
   task automatic advance();
      if (!reset_n)
         tickCount = 0;
      else if (ce_in)
         tickCount++;
      @(negedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
      end
   endtask

   // Issue the trigger write on a tick whose phase equals trigParity.
   task automatic triggerDma(input logic [7:0] page, input logic trigParity);
      cpu_w = 1'b0;
      cpu_r = 1'b0;
      cpu_a = 16'h0000;
      applyStimulus(1'b0);
      advance();
      if ((tickCount % 2) != int'(trigParity)) begin
         applyStimulus(1'b1);
         advance();
         applyStimulus(1'b0);
         advance();
      end
      cpu_a = DMA_REG;
      cpu_d = page;
      cpu_w = 1'b1;
      applyStimulus(1'b1);
      checkOutput("trigAddr", bus_a, DMA_REG);
      checkOutput("trigStrobe", 16'({cpu_ce, bus_w, busy}), 16'b110);
      advance();
   endtask

   // Run one transfer with ce_in high once every 'period' clocks, collecting
   // per-tick statistics. With abortIdx >= 0 the task returns at the sample
   // point where the engine is reading that index.
   task automatic runDma(input logic [7:0] page, input int period,
                         input logic trigParity, input logic [7:0] key,
                         input int abortIdx);
      logic [27:0] prevOut;
      logic        prevBusy, prevCe, lastWasRead;
      int          maxClk;
      triggerDma(page, trigParity);
      writes = 0; reads = 0; halted = 0; quiet = 0;
      addrErr = 0; dataErr = 0; orderErr = 0; stableErr = 0; cpuCeErr = 0;
      done = 1'b0; aborted = 1'b0; lastRead = 16'h0000;
      prevOut = '0; prevBusy = 1'b0; prevCe = 1'b1; lastWasRead = 1'b0;
      maxClk = 600 * period + 50;
      for (int c = 1; c <= maxClk; c++) begin
         cpu_w = (c < 20);
         cpu_a = (c < 20) ? DMA_REG : 16'h5555;
         cpu_d = 8'h77;
         cpu_r = 1'b1;
         applyStimulus((c % period) == 0);
         if (!busy) begin
            done = 1'b1;
            break;
         end
         if (cpu_ce !== 1'b0) cpuCeErr++;
         if (prevBusy && !prevCe && ({bus_a, bus_d, bus_r, bus_w, busy, cpu_ce} !== prevOut))
            stableErr++;
         if (ce_in) begin
            halted++;
            if (bus_r) begin
               if (bus_a !== {page, reads[7:0]} || bus_w) addrErr++;
               if (lastWasRead) orderErr++;
               if (reads == abortIdx) begin
                  aborted = 1'b1;
                  return;
               end
               lastRead = bus_a;
               lastWasRead = 1'b1;
               reads++;
            end else if (bus_w) begin
               if (bus_a !== OAM_REG) addrErr++;
               if (!lastWasRead) orderErr++;
               if (bus_d !== (writes[7:0] ^ key)) dataErr++;
               lastWasRead = 1'b0;
               writes++;
            end else begin
               quiet++;
            end
         end
         prevOut  = {bus_a, bus_d, bus_r, bus_w, busy, cpu_ce};
         prevBusy = busy;
         prevCe   = ce_in;
         advance();
      end
      checkOutput("dmaFinished", 16'(done), 16'd1);
      checkOutput("haltedTicks", 16'(halted), trigParity ? 16'd513 : 16'd514);
      checkOutput("quietTicks", 16'(quiet), trigParity ? 16'd1 : 16'd2);
      checkOutput("oamWrites", 16'(writes), 16'd256);
      checkOutput("srcReads", 16'(reads), 16'd256);
      checkOutput("addrErrors", 16'(addrErr), 16'd0);
      checkOutput("dataErrors", 16'(dataErr), 16'd0);
      checkOutput("orderErrors", 16'(orderErr), 16'd0);
      checkOutput("holdErrors", 16'(stableErr), 16'd0);
      checkOutput("cpuCeLow", 16'(cpuCeErr), 16'd0);
      checkOutput("lastReadAddr", lastRead, {page, 8'hFF});
      checkOutput("busReleased", bus_a, 16'h5555);
      checkOutput("cpuCeReturn", 16'(cpu_ce), 16'(ce_in));
      cpu_r = 1'b0;
      cpu_w = 1'b0;
      advance();
   endtask

   initial begin
      reset_n = 1'b0;
      ce_in   = 1'b0;
      cpu_a   = 16'h0000;
      cpu_d   = 8'h00;
      cpu_r   = 1'b0;
      cpu_w   = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'hE1;
      for (int i = 0; i < 256; i++) begin
         mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
         mem[16'hFF00 + i] = 8'(i) ^ 8'hC3;
      end

      // Reset, with ticks arriving while reset is held.
      @(negedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i[0]);
         advance();
      end
      applyStimulus(1'b0);
      checkOutput("resetBusy", 16'(busy), 16'd0);
      checkOutput("resetCeLow", 16'(cpu_ce), 16'd0);
      applyStimulus(1'b1);
      checkOutput("resetCeHigh", 16'(cpu_ce), 16'd1);
      advance();
      applyStimulus(1'b0);
      reset_n = 1'b1;
      advance();

      // Idle pass-through.
      cpu_a = 16'h0123;
      cpu_r = 1'b1;
      applyStimulus(1'b0);
      checkOutput("passAddr", bus_a, 16'h0123);
      checkOutput("passRead", 16'({bus_r, bus_w, busy, cpu_ce}), 16'b1000);
      applyStimulus(1'b1);
      checkOutput("passCe", 16'(cpu_ce), 16'd1);
      advance();
      cpu_r = 1'b0;
      cpu_a = 16'h3000;
      cpu_d = 8'hA5;
      cpu_w = 1'b1;
      applyStimulus(1'b0);
      checkOutput("passWrData", 16'(bus_d), 16'h00A5);
      checkOutput("passWrite", 16'({bus_r, bus_w}), 16'b01);
      advance();

      // A trigger write without a tick must be ignored.
      cpu_a = DMA_REG;
      cpu_d = 8'h11;
      applyStimulus(1'b0);
      advance();
      cpu_w = 1'b0;
      applyStimulus(1'b0);
      checkOutput("noTickTrigger", 16'(busy), 16'd0);
      advance();

      $display("[TB] even-start transfer, page 02");
      runDma(8'h02, 2, 1'b1, 8'h5A, -1);

      $display("[TB] odd-start transfer, page 02");
      runDma(8'h02, 2, 1'b0, 8'h5A, -1);

      $display("[TB] page FF transfer");
      runDma(8'hFF, 2, 1'b1, 8'hC3, -1);

      $display("[TB] sparse tick transfer");
      runDma(8'h02, 12, 1'b0, 8'h5A, -1);

      $display("[TB] reset during transfer");
      runDma(8'h02, 2, 1'b1, 8'h5A, 'h40);
      checkOutput("abortReached", 16'(aborted), 16'd1);
      checkOutput("abortReadAddr", bus_a, 16'h0240);
      reset_n = 1'b0;
      advance();
      cpu_w = 1'b0;
      cpu_r = 1'b0;
      cpu_a = 16'h5555;
      applyStimulus(1'b0);
      checkOutput("abortBusy", 16'(busy), 16'd0);
      checkOutput("abortCeLow", 16'(cpu_ce), 16'd0);
      checkOutput("abortBus", bus_a, 16'h5555);
      applyStimulus(1'b1);
      checkOutput("abortCeHigh", 16'(cpu_ce), 16'd1);
      reset_n = 1'b1;
      advance();
      strayW = 0;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(c[0]);
         if (busy || bus_w || bus_a === OAM_REG) strayW++;
         advance();
      end
      checkOutput("abortNoWrites", 16'(strayW), 16'd0);

      $display("[TB] fresh transfer after reset");
      runDma(8'h02, 2, 1'b1, 8'h5A, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
